seq_shift_right: RTL and testbench
==================================

// Module: seq_shift_right
// PURPOSE
//  Multi-cycle right-shift unit for the 16-bit datapath, covering the right-going
//  operations the single-cycle SLL/SRA barrel shifter does not: logical shift right
//  (SRL) and rotate right (ROR). Shifts one bit position per clock under a
//  start/done handshake.
//  Sits beside the ALU; the execute-stage controller stalls while busy is high.
// PARAMETERS
//  WIDTH  16  data width in bits
//  AMT_W   4  shift-amount width; legal amounts are 0..2**AMT_W-1
// PORTS
//  clk       in   1      system clock, all state on rising edge
//  rst       in   1      asynchronous, active-high reset
//  start     in   1      request; sampled only in IDLE or DONE
//  mode      in   1      0 = ROR, 1 = SRL; latched on accepted start
//  data_in   in   WIDTH  operand; latched on accepted start
//  amt       in   AMT_W  shift amount; latched on accepted start
//  busy      out  1      high while state == SHIFT
//  done      out  1      one-cycle pulse: data_out holds the final result
//  data_out  out  WIDTH  working/result register, held until next accepted start
// BEHAVIOUR
//  Reset (async, rst=1): state=IDLE, data_reg=0, cnt=0, mode_reg=0; busy=0, done=0, data_out=0.
//  States: IDLE, SHIFT, DONE (2-bit encoded). busy = (state==SHIFT); done = (state==DONE).
//  Accepted start = start & (state==IDLE | state==DONE):
//    data_reg<=data_in, cnt<=amt, mode_reg<=mode; next = (amt==0) ? DONE : SHIFT.
//  SHIFT, each cycle:
//    ROR: data_reg <= {data_reg[0], data_reg[WIDTH-1:1]}
//    SRL: data_reg <= {1'b0, data_reg[WIDTH-1:1]}
//    cnt <= cnt-1; if cnt==1 then next=DONE else stay in SHIFT.
//  DONE: lasts exactly one cycle. Next state is the start path (above) if start=1,
//    else IDLE.
//  Latency: start sampled at edge 0 -> done high in cycle amt+1 (amt=0 -> cycle 1).
//  start in SHIFT is ignored: no latch, no restart, inputs may change freely.
//  Back-to-back: start during DONE is accepted; data_out changes on that same edge.
//  data_out = data_reg directly, no output register. Intermediate values are visible
//    during SHIFT; only the DONE-cycle value is architecturally valid.
//  ROR by k equals rotate by k mod WIDTH; ROR by 0 and SRL by 0 return data_in.
//  SRL never sign-extends; bit WIDTH-1 fills with 0 regardless of data_in[WIDTH-1].
//  Reset mid-operation: aborts immediately to the reset values; no done pulse is issued.
//  cnt is AMT_W bits wide and never wraps: SHIFT exits at cnt==1 before reaching 0.
// TESTING
//  1 ROR 0x8001, amt=1, start at cycle 0 -> busy cycle 1, done cycle 2, data_out=0xC000.
//  2 ROR 0x1234 amt=4 -> 0x4123 at done (cycle 5); SRL 0x8000 amt=15 -> 0x0001 at
//    done (cycle 16), busy high cycles 1..15.
//  3 SRL 0xFFFF amt=0 -> no busy, done cycle 1, data_out=0xFFFF; ROR 0xA5A5 amt=0 -> 0xA5A5.
//  4 SRL 0xF000 amt=3, then pulse start with 0x0001/amt=1 at cycle 2 -> ignored;
//    done cycle 4, data_out=0x1E00.
//  5 start with amt=2 held high through DONE, new operand 0x0003 ROR amt=1 ->
//    second op accepted on the DONE edge, next done pulse 2 cycles later = 0x8001.
//  6 SRL 0xFFFF amt=8, assert rst asynchronously mid-SHIFT -> busy, done and data_out
//    drop to 0 immediately with no clock edge; start after release runs normally.

Source files
------------

// File: rtl/seq_shift_right.sv
// Multi-cycle SRL/ROR unit: one bit per clock, done pulses amt+1 cycles after an accepted start.
// The execute stage stalls while busy is high; start is ignored during SHIFT.
module seq_shift_right #(
   parameter int WIDTH = 16,
   parameter int AMT_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             mode,
   input  logic [WIDTH-1:0] data_in,
   input  logic [AMT_W-1:0] amt,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] data_out
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   data_q, data_d;
   logic [AMT_W-1:0]   cnt_q, cnt_d;
   logic               mode_q, mode_d;
   logic               busy_q, done_q;
   logic               accept;

   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      cnt_d   = cnt_q;
      mode_d  = mode_q;
      accept  = start && (state_q == ST_IDLE || state_q == ST_DONE);

      case (state_q)
         ST_SHIFT: begin
            // mode 1 (SRL) fills the top with zero; mode 0 (ROR) recirculates bit 0
            data_d = {(mode_q ? 1'b0 : data_q[0]), data_q[WIDTH-1:1]};
            cnt_d  = cnt_q - AMT_W'(1);
            if (cnt_q == AMT_W'(1)) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase

      if (accept) begin
         data_d  = data_in;
         cnt_d   = amt;
         mode_d  = mode;
         state_d = (amt == '0) ? ST_DONE : ST_SHIFT;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         data_q  <= '0;
         cnt_q   <= '0;
         mode_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         cnt_q   <= cnt_d;
         mode_q  <= mode_d;
         busy_q  <= (state_d == ST_SHIFT);
         done_q  <= (state_d == ST_DONE);
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign data_out = data_q;

endmodule

// File: tb/tb_seq_shift_right.sv
// Directed bench for seq_shift_right: latency, result values, ignored start, back-to-back and async reset.
module tb_seq_shift_right;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        mode;
   logic [15:0] data_in;
   logic [3:0]  amt;
   logic        busy;
   logic        done;
   logic [15:0] data_out;

   int n_assert = 0;
   int n_fail   = 0;

   seq_shift_right #(.WIDTH(16), .AMT_W(4)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .mode     (mode),
      .data_in  (data_in),
      .amt      (amt),
      .busy     (busy),
      .done     (done),
      .data_out (data_out)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Starts one op, waits (bounded) for done, checks latency, busy span and result, then returns to IDLE.
   task automatic run_op(input string tag, input logic m, input logic [15:0] d,
                         input logic [3:0] a, input logic [15:0] exp);
      int cyc;
      int bcnt;
      start = 1'b1; mode = m; data_in = d; amt = a;
      tick();
      start = 1'b0;
      cyc  = 1;
      bcnt = 0;
      while (done !== 1'b1 && cyc < 40) begin
         if (busy === 1'b1) bcnt++;
         tick();
         cyc++;
      end
      chk({tag, "_done"},    32'(done),     32'd1);
      chk({tag, "_latency"}, 32'(cyc),      32'(a) + 32'd1);
      chk({tag, "_busycyc"}, 32'(bcnt),     32'(a));
      chk({tag, "_busy_at_done"}, 32'(busy), 32'd0);
      chk({tag, "_data"},    32'(data_out), 32'(exp));
      tick();
      chk({tag, "_idle_done"}, 32'(done),   32'd0);
      chk({tag, "_held"},    32'(data_out), 32'(exp));
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; mode = 1'b0; data_in = '0; amt = '0;
      tick();
      tick();
      chk("rst_busy", 32'(busy),     32'd0);
      chk("rst_done", 32'(done),     32'd0);
      chk("rst_data", 32'(data_out), 32'd0);
      rst = 1'b0;
      tick();
      chk("idle_done", 32'(done), 32'd0);

      // 1: cycle-by-cycle ROR 0x8001 by 1
      start = 1'b1; mode = 1'b0; data_in = 16'h8001; amt = 4'd1;
      tick();
      start = 1'b0;
      chk("t1_c1_busy", 32'(busy), 32'd1);
      chk("t1_c1_done", 32'(done), 32'd0);
      tick();
      chk("t1_c2_busy", 32'(busy),     32'd0);
      chk("t1_c2_done", 32'(done),     32'd1);
      chk("t1_c2_data", 32'(data_out), 32'h0000_C000);
      tick();
      chk("t1_c3_done", 32'(done),     32'd0);

      // 2, 3 and extra boundaries
      run_op("t2_ror4",   1'b0, 16'h1234, 4'd4,  16'h4123);
      run_op("t2_srl15",  1'b1, 16'h8000, 4'd15, 16'h0001);
      run_op("t3_srl0",   1'b1, 16'hFFFF, 4'd0,  16'hFFFF);
      run_op("t3_ror0",   1'b0, 16'hA5A5, 4'd0,  16'hA5A5);
      run_op("x_ror15",   1'b0, 16'h0001, 4'd15, 16'h0002);
      run_op("x_srl4",    1'b1, 16'h8421, 4'd4,  16'h0842);

      // 4: start during SHIFT is ignored
      start = 1'b1; mode = 1'b1; data_in = 16'hF000; amt = 4'd3;
      tick();
      start = 1'b0;
      tick();
      start = 1'b1; mode = 1'b0; data_in = 16'h0001; amt = 4'd1;
      tick();
      start = 1'b0;
      chk("t4_c3_busy", 32'(busy), 32'd1);
      chk("t4_c3_done", 32'(done), 32'd0);
      tick();
      chk("t4_c4_done", 32'(done),     32'd1);
      chk("t4_c4_data", 32'(data_out), 32'h0000_1E00);
      tick();
      chk("t4_c5_done", 32'(done), 32'd0);

      // 5: start held through DONE accepts the next op on the DONE edge
      start = 1'b1; mode = 1'b0; data_in = 16'h0004; amt = 4'd2;
      tick();
      mode = 1'b0; data_in = 16'h0003; amt = 4'd1;
      tick();
      tick();
      chk("t5_c3_done", 32'(done),     32'd1);
      chk("t5_c3_data", 32'(data_out), 32'h0000_0001);
      tick();
      start = 1'b0;
      chk("t5_c4_busy", 32'(busy),     32'd1);
      chk("t5_c4_done", 32'(done),     32'd0);
      chk("t5_c4_data", 32'(data_out), 32'h0000_0003);
      tick();
      chk("t5_c5_done", 32'(done),     32'd1);
      chk("t5_c5_data", 32'(data_out), 32'h0000_8001);
      tick();

      // 6: async reset mid-SHIFT
      start = 1'b1; mode = 1'b1; data_in = 16'hFFFF; amt = 4'd8;
      tick();
      start = 1'b0;
      tick();
      tick();
      chk("t6_pre_busy", 32'(busy), 32'd1);
      #2;
      rst = 1'b1;
      #1;
      chk("t6_rst_busy", 32'(busy),     32'd0);
      chk("t6_rst_done", 32'(done),     32'd0);
      chk("t6_rst_data", 32'(data_out), 32'd0);
      tick();
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("t6_no_done", 32'(done), 32'd0);
      end
      run_op("t6_after", 1'b1, 16'h1234, 4'd2, 16'h048D);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
